// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one unified word memory between the instruction-fetch port (i_*)
//   and the load/store port (d_*). One request is taken at a time over a
//   valid/ready handshake. An accepted request owns the memory for a single
//   ACCESS cycle and is answered with a one-cycle rvalid pulse in the
//   following RESP cycle. A new request may be accepted during RESP, so a
//   sustained stream gets one memory access every two cycles.
//
// Ports
//   clk, reset                async active-high reset
//   i_valid/i_addr            fetch request in
//   i_ready                   fetch request accepted this cycle
//   i_rvalid/i_rdata          fetch response (one-cycle pulse)
//   d_valid/d_we/d_addr/d_wdata  load/store request in
//   d_ready                   data request accepted this cycle
//   d_rvalid/d_rdata/d_err    data response; d_err marks a misaligned request
//                             that never reached the memory
//   mem_address/mem_data_in/mem_we  memory port (held stable outside ACCESS)
//   mem_data_out              combinational read data from the memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FAIR       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_valid,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  state_t state_nxt;

  logic can_accept;
  logic grant_d;
  logic accept;
  logic misaligned;
  logic last_grant_d;   // 1 = data port won the last grant, 0 = fetch

  logic                  req_port_p1;  // 1 = data port owns the request
  logic                  req_we_p1;
  logic                  req_err_p1;
  logic [ADDR_WIDTH-1:0] req_addr_p1;
  logic [DATA_WIDTH-1:0] req_wdata_p1;
  logic [DATA_WIDTH-1:0] rsp_data_p2;

  // Arbitration: ready is a combinational function of the valids and state.
  // With FAIR set, a contested grant goes to whoever did not win last time;
  // last_grant_d resets to fetch so the first contested grant goes to data.
  always_comb begin
    can_accept = (state == IDLE) || (state == RESP);
    if (i_valid && d_valid) begin
      grant_d = (FAIR == 0) ? 1'b1 : !last_grant_d;
    end else begin
      grant_d = d_valid;
    end
    d_ready    = can_accept && d_valid && grant_d;
    i_ready    = can_accept && i_valid && !grant_d;
    accept     = d_ready || i_ready;
    misaligned = d_ready && (d_addr[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a misaligned data request skips the memory cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (misaligned) begin
          state_nxt = RESP;
        end else if (accept) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. The memory address/data come straight from the request latch,
  // so they only move when an aligned request is accepted.
  always_comb begin
    mem_we      = (state == ACCESS) && req_we_p1;
    mem_address = req_addr_p1;
    mem_data_in = req_wdata_p1;
    i_rvalid    = (state == RESP) && !req_port_p1;
    d_rvalid    = (state == RESP) && req_port_p1;
    d_err       = (state == RESP) && req_port_p1 && req_err_p1;
    i_rdata     = rsp_data_p2;
    d_rdata     = rsp_data_p2;
  end

  // ---- stage p1: request latch (acceptance edge) ----
  // ---- stage p2: response register (end of ACCESS) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_d <= 1'b0;
      req_port_p1  <= 1'b0;
      req_we_p1    <= 1'b0;
      req_err_p1   <= 1'b0;
      req_addr_p1  <= '0;
      req_wdata_p1 <= '0;
      rsp_data_p2  <= '0;
    end else begin
      if (accept) begin
        last_grant_d <= d_ready;
        req_port_p1  <= d_ready;
        req_err_p1   <= misaligned;
        req_we_p1    <= d_ready && d_we && !misaligned;
        if (!misaligned) begin
          req_addr_p1 <= d_ready ? d_addr : i_addr;
        end
        if (d_ready && !misaligned) begin
          req_wdata_p1 <= d_wdata;
        end
      end
      if (state == ACCESS) begin
        rsp_data_p2 <= req_we_p1 ? '0 : mem_data_out;
      end else if (misaligned) begin
        rsp_data_p2 <= '0;
      end
    end
  end

endmodule
